// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised XNOR LFSR word generator with a valid/ready
// output stream and a start/stop/burst-count control FSM.
// Each word carries OUT_BITS freshly generated bits; the earliest bit sits at
// o_Data[OUT_BITS-1] and the newest at o_Data[0].
// Optional feature macro: LFSR_LOCKUP_GUARD_EN. When defined, an all-ones seed
// (the XNOR lockup state) is replaced by zero and o_Seed_Err pulses.
module lfsr_stream #(
    parameter int                  NUM_BITS   = 16,
    parameter logic [NUM_BITS-1:0] TAPS       = 16'hD008,
    parameter int                  OUT_BITS   = 8,
    parameter int                  COUNT_BITS = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Seed_DV,
    input  logic [NUM_BITS-1:0]   i_Seed_Data,
    input  logic                  i_Start,
    input  logic                  i_Stop,
    input  logic [COUNT_BITS-1:0] i_Count,
    output logic [OUT_BITS-1:0]   o_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Wrap,
    output logic                  o_Seed_Err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [NUM_BITS-1:0]     lfsr_r;
    logic [NUM_BITS-1:0]     seed_r;
    logic [NUM_BITS-1:0]     next_s;
    logic [NUM_BITS-1:0]     seed_val_s;
    logic                    seed_lock_s;
    logic [COUNT_BITS-1:0]   cnt_r;
    logic [COUNT_BITS-1:0]   cnt_inc_s;
    logic [COUNT_BITS-1:0]   count_lat_r;
    logic                    hs_s;
    logic                    last_s;
    logic                    done_r;
    logic                    wrap_r;
    logic                    seed_err_r;

    // One XNOR LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [NUM_BITS-1:0] lfsr_step(input logic [NUM_BITS-1:0] v);
        logic fb;
        fb = ~(^(v & TAPS));
        return {v[NUM_BITS-2:0], fb};
    endfunction

    // Unroll OUT_BITS single steps to form the next word state.
    always_comb begin
        next_s = lfsr_r;
        for (int i = 0; i < OUT_BITS; i++) begin
            next_s = lfsr_step(next_s);
        end
    end

    // Seed qualification: optionally steer the all-ones lockup seed to zero.
    always_comb begin
`ifdef LFSR_LOCKUP_GUARD_EN
        seed_lock_s = (i_Seed_Data == {NUM_BITS{1'b1}});
        if (seed_lock_s) begin
            seed_val_s = {NUM_BITS{1'b0}};
        end else begin
            seed_val_s = i_Seed_Data;
        end
`else
        seed_lock_s = 1'b0;
        seed_val_s  = i_Seed_Data;
`endif
    end

    // Handshake, counter increment and final-word detection.
    always_comb begin
        hs_s      = (state_r == ST_RUN) && i_Ready;
        cnt_inc_s = cnt_r + {{(COUNT_BITS-1){1'b0}}, 1'b1};
        if (hs_s && (count_lat_r != {COUNT_BITS{1'b0}})) begin
            last_s = (cnt_inc_s == count_lat_r);
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic: start leaves IDLE; final word or stop leaves RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s || i_Stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: seed load, burst setup, word advance and event pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            lfsr_r      <= {NUM_BITS{1'b0}};
            seed_r      <= {NUM_BITS{1'b0}};
            cnt_r       <= {COUNT_BITS{1'b0}};
            count_lat_r <= {COUNT_BITS{1'b0}};
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
            seed_err_r  <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            wrap_r     <= 1'b0;
            seed_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_Seed_DV) begin
                        lfsr_r     <= seed_val_s;
                        seed_r     <= seed_val_s;
                        seed_err_r <= seed_lock_s;
                    end
                    if (i_Start) begin
                        count_lat_r <= i_Count;
                        cnt_r       <= {COUNT_BITS{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        lfsr_r <= next_s;
                        cnt_r  <= cnt_inc_s;
                        wrap_r <= (next_s == seed_r);
                        done_r <= last_s;
                    end
                end
                default: begin
                    cnt_r <= {COUNT_BITS{1'b0}};
                end
            endcase
        end
    end

    assign o_Data     = next_s[OUT_BITS-1:0];
    assign o_Valid    = (state_r == ST_RUN);
    assign o_Busy     = (state_r == ST_RUN);
    assign o_Done     = done_r;
    assign o_Wrap     = wrap_r;
    assign o_Seed_Err = seed_err_r;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: a 4-bit single-bit-word instance and a default
// 16-bit/8-bit-word instance share one stimulus stream and are compared every
// cycle against a bit-stream reference model, plus literal sequence checks.
module tb_lfsr_stream;

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int          C_N  [2] = '{4, 16};
    localparam int unsigned C_T  [2] = '{32'hC, 32'hD008};
    localparam int          C_OB [2] = '{1, 8};
    localparam int          C_CB [2] = '{4, 16};

    logic        i_Clk = 1'b0;
    logic        rst_n;
    logic        seed_dv;
    logic [15:0] seed_data;
    logic        start;
    logic        stop;
    logic [15:0] count;
    logic        ready;

    logic [0:0]  s_data;
    logic        s_valid, s_busy, s_done, s_wrap, s_err;
    logic [7:0]  b_data;
    logic        b_valid, b_busy, b_done, b_wrap, b_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int unsigned m_lfsr [2];
    int unsigned m_seed [2];
    int unsigned m_cnt  [2];
    int unsigned m_lat  [2];
    bit          m_run  [2];
    bit          m_done [2];
    bit          m_wrap [2];
    bit          m_err  [2];

    always #5 i_Clk = ~i_Clk;

    lfsr_stream #(.NUM_BITS(4), .TAPS(4'b1100), .OUT_BITS(1), .COUNT_BITS(4)) u_small (
        .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data[3:0]),
        .i_Start(start), .i_Stop(stop), .i_Count(count[3:0]), .o_Data(s_data),
        .o_Valid(s_valid), .i_Ready(ready), .o_Busy(s_busy), .o_Done(s_done),
        .o_Wrap(s_wrap), .o_Seed_Err(s_err)
    );

    lfsr_stream u_big (
        .i_Clk(i_Clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data),
        .i_Start(start), .i_Stop(stop), .i_Count(count), .o_Data(b_data),
        .o_Valid(b_valid), .i_Ready(ready), .o_Busy(b_busy), .o_Done(b_done),
        .o_Wrap(b_wrap), .o_Seed_Err(b_err)
    );

    function automatic int unsigned nmask(int k);
        return (C_N[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << C_N[k]) - 32'd1);
    endfunction

    // Generate one bit: XNOR of the tapped stages, appended as the new LSB.
    function automatic int unsigned gen_state(int unsigned v, int k);
        bit fb;
        fb = ~(^(v & C_T[k]));
        return ((v << 1) | 32'(fb)) & nmask(k);
    endfunction

    // Word = the next OUT_BITS generated bits, earliest in the MSB.
    function automatic int unsigned gen_word(int unsigned v, int k);
        int unsigned d;
        d = 0;
        for (int i = 0; i < C_OB[k]; i++) begin
            v = gen_state(v, k);
            d = (d << 1) | (v & 32'd1);
        end
        return d;
    endfunction

    function automatic int unsigned adv(int unsigned v, int k);
        for (int i = 0; i < C_OB[k]; i++) v = gen_state(v, k);
        return v;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated on each clock edge and on async reset.
    initial begin
        forever begin
            @(posedge i_Clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    m_lfsr[k] = 0; m_seed[k] = 0; m_cnt[k] = 0; m_lat[k] = 0;
                    m_run[k] = 0; m_done[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
                end else begin
                    int unsigned cm, sv, w;
                    cm = (32'd1 << C_CB[k]) - 32'd1;
                    m_done[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
                    if (!m_run[k]) begin
                        if (seed_dv) begin
                            sv = 32'(seed_data) & nmask(k);
                            if (GUARD && sv == nmask(k)) begin
                                sv = 0;
                                m_err[k] = 1;
                            end
                            m_seed[k] = sv;
                            m_lfsr[k] = sv;
                        end
                        if (start) begin
                            m_run[k] = 1;
                            m_lat[k] = 32'(count) & cm;
                            m_cnt[k] = 0;
                        end
                    end else begin
                        if (ready) begin
                            w = adv(m_lfsr[k], k);
                            m_cnt[k]  = (m_cnt[k] + 1) & cm;
                            m_done[k] = (m_lat[k] != 0) && (m_cnt[k] == m_lat[k]);
                            m_wrap[k] = (w == m_seed[k]);
                            m_lfsr[k] = w;
                            if (m_done[k]) m_run[k] = 0;
                        end
                        if (stop) m_run[k] = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge i_Clk);
            if (cmp_en) begin
                chk("s_valid", s_valid, m_run[0]);
                chk("s_busy",  s_busy,  m_run[0]);
                chk("s_done",  s_done,  m_done[0]);
                chk("s_wrap",  s_wrap,  m_wrap[0]);
                chk("s_err",   s_err,   m_err[0]);
                if (m_run[0]) chk("s_data", s_data, gen_word(m_lfsr[0], 0));
                chk("b_valid", b_valid, m_run[1]);
                chk("b_busy",  b_busy,  m_run[1]);
                chk("b_done",  b_done,  m_done[1]);
                chk("b_wrap",  b_wrap,  m_wrap[1]);
                chk("b_err",   b_err,   m_err[1]);
                if (m_run[1]) chk("b_data", b_data, gen_word(m_lfsr[1], 1));
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        bit [0:0] lit [7];
        int wraps, first_wrap;
        logic [0:0] hold_s;
        logic [7:0] hold_b;
        lit = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0; seed_dv = 1'b0; seed_data = 16'h0; start = 1'b0;
        stop = 1'b0; count = 16'h0; ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge i_Clk);
        chk("rst_valid", s_valid, 0);
        chk("rst_busy", b_busy, 0);

        // Free-running burst from the reset state.
        tick(); start = 1'b1; count = 16'd0; ready = 1'b1;
        tick(); start = 1'b0;
        wraps = 0; first_wrap = 0;
        for (int w = 1; w <= 31; w++) begin
            @(negedge i_Clk);
            if (w <= 7) chk("seq_lit", s_data, lit[w-1]);
            if (w == 1) chk("big_first", b_data, 8'hF0);
            if (w >= 2 && s_wrap) begin
                wraps++;
                if (first_wrap == 0) first_wrap = w;
            end
        end
        chk("wrap_count", wraps, 2);
        chk("wrap_pos", first_wrap, 16);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;

        // Reseed to zero and run a 15-word burst.
        seed_dv = 1'b1; seed_data = 16'h0; start = 1'b1; count = 16'd15;
        tick(); seed_dv = 1'b0; start = 1'b0;
        repeat (16) @(negedge i_Clk);
        chk("burst_done", s_done, 1);
        chk("burst_wrap", s_wrap, 1);
        chk("burst_valid", s_valid, 0);
        chk("big_done", b_done, 1);

        // Stop at word 3 of a 10-word burst, then restart without reseed.
        tick(); start = 1'b1; count = 16'd10;
        tick(); start = 1'b0;
        @(negedge i_Clk);
        tick();
        @(negedge i_Clk);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge i_Clk);
        chk("stop_valid", s_valid, 0);
        chk("stop_done", s_done, 0);
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge i_Clk);
        chk("restart_w4", s_data, 0);

        // Back-pressure: data frozen for five cycles.
        ready = 1'b0;
        hold_s = s_data; hold_b = b_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clk);
            chk("hold_s", s_data, hold_s);
            chk("hold_b", b_data, hold_b);
        end
        tick(); ready = 1'b1;
        repeat (14) tick();

        // Asynchronous reset during a free-running burst.
        start = 1'b1; count = 16'd0;
        tick(); start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", s_valid, 0);
        chk("arst_busy", b_busy, 0);
        chk("arst_wrap", s_wrap | b_wrap, 0);
        chk("arst_done", s_done | b_done, 0);
        tick(); rst_n = 1'b1;
        repeat (5) @(negedge i_Clk);
        chk("post_rst_valid", s_valid, 0);

        // All-ones seed: lockup or guarded replacement.
        tick(); seed_dv = 1'b1; seed_data = 16'hFFFF; start = 1'b1; count = 16'd0;
        tick(); seed_dv = 1'b0; start = 1'b0;
        @(negedge i_Clk);
        chk("seed_err", s_err, GUARD);
        chk("lock_data", s_data, 1);
        @(negedge i_Clk);
        chk("lock_wrap", s_wrap, !GUARD);
        repeat (6) tick();
        stop = 1'b1;
        tick(); stop = 1'b0;

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            seed_dv   = ($urandom_range(0, 7) == 0);
            seed_data = 16'($urandom);
            if ($urandom_range(0, 9) == 0) seed_data = 16'hFFFF;
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 19) == 0);
            count     = 16'($urandom_range(0, 15));
            ready     = ($urandom_range(0, 9) < 7);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
        end
        tick();
        @(negedge i_Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
- Parametrised successor of the team's single-step XNOR LFSR.
- Configurable width, tap mask and bits-per-word, so it produces OUT_BITS new pseudo-random bits per output word.
- Words are delivered over a valid/ready stream with a start/stop/burst-count control FSM, plus period-wrap and done pulses.
- Feeds test-pattern and noise generators (e.g. MAX7219 framebuffer fill) in the Cmod A7 designs.

Parameters:
- NUM_BITS, 16, LFSR width, legal 3..32.
- TAPS, 16'hD008, feedback mask: bit k-1 set means stage k is tapped. Default is taps 16,15,13,4.
- OUT_BITS, 8, new bits per word, legal 1..NUM_BITS.
- COUNT_BITS, 16, width of the burst word counter.

Ports:
- i_Clk  in  1  clock
- i_Rst_n  in  1  async active-low reset
- i_Seed_DV  in  1  load seed (accepted only in IDLE)
- i_Seed_Data  in  NUM_BITS  seed value
- i_Start  in  1  start burst (accepted only in IDLE)
- i_Stop  in  1  abort burst
- i_Count  in  COUNT_BITS  burst length in words; 0 = free-running
- o_Data  out  OUT_BITS  current word
- o_Valid  out  1  word available
- i_Ready  in  1  consumer accepts word
- o_Busy  out  1  FSM in RUN
- o_Done  out  1  1-cycle pulse, burst complete
- o_Wrap  out  1  1-cycle pulse, LFSR returned to seed
- o_Seed_Err  out  1  lockup seed replaced (LFSR_LOCKUP_GUARD_EN only, else tied 0)

Behaviour:
- Reset (async assert, sync release) clears everything:
  - FSM = IDLE; r_LFSR = 0; r_Seed = 0; word counter = 0.
  - o_Valid = o_Busy = o_Done = o_Wrap = o_Seed_Err = 0.
  - Reset mid-burst aborts immediately with no o_Done.
- Single step:
  - fb = XNOR-reduce(r_LFSR & TAPS).
  - r_LFSR <= {r_LFSR[NUM_BITS-2:0], fb}.
  - All-ones is the lockup state; 0 is legal.
- Word step:
  - r_Next = r_LFSR advanced OUT_BITS single steps (unrolled combinationally, same cycle).
  - o_Data = r_Next[OUT_BITS-1:0]. Newest bit is at bit 0; the earliest generated bit is at bit OUT_BITS-1.
- FSM IDLE:
  - o_Valid = 0.
  - i_Seed_DV loads r_Seed and r_LFSR from i_Seed_Data.
  - i_Start latches i_Count, clears the counter, moves to RUN next cycle.
  - i_Start and i_Seed_DV in the same cycle: seed is loaded and RUN is entered; the first word derives from the new seed.
- FSM RUN:
  - o_Valid = 1, o_Busy = 1.
  - Handshake (o_Valid & i_Ready): r_LFSR <= r_Next, counter += 1.
  - o_Data and o_Valid stay stable while i_Ready = 0.
  - i_Seed_DV and i_Start are ignored in RUN.
- Done: on the handshake of word number i_Count (latched, nonzero):
  - o_Done pulses the next cycle.
  - FSM returns to IDLE and o_Valid drops that same next cycle.
- Free-running (count 0): the counter wraps modulo 2^COUNT_BITS with no o_Done.
- Stop: i_Stop in RUN returns to IDLE next cycle with no o_Done.
  - A handshake coinciding with i_Stop still completes and advances the LFSR.
  - i_Stop and the final handshake in the same cycle: o_Done still pulses.
  - i_Stop in IDLE is ignored.
- Wrap: o_Wrap pulses the cycle after a handshake where r_Next == r_Seed. Detection is at word granularity only.
- r_LFSR is preserved across bursts. A new i_Start without a reseed continues the sequence.

Optional Feature:
- Macro: LFSR_LOCKUP_GUARD_EN.
- Defined: a seed load with i_Seed_Data all-ones loads 0 into both r_LFSR and r_Seed instead, and o_Seed_Err pulses 1 cycle.
- Not defined: the seed loads verbatim, an all-ones seed locks the LFSR at all-ones, and o_Seed_Err is constant 0.

Test Plan:
- NUM_BITS=4, TAPS=4'b1100, OUT_BITS=1, reset, i_Start with i_Count=0, i_Ready=1 -> o_Data sequence 1,1,1,0,1,1,0; state sequence 0001,0011,0111,1110,1101,1011,0110; period 15; o_Wrap once every 15 words.
- Same config, i_Count=15 -> 15 words, then o_Done and o_Wrap pulse in the same cycle, o_Valid=0 after, o_Busy=0.
- Hold i_Ready=0 for 5 cycles mid-burst -> o_Data constant, no state advance; the word counter resumes exactly on release.
- i_Stop at word 3 of i_Count=10 -> IDLE, no o_Done; a restart without reseed continues the sequence at word 4.
- Reset asserted mid-burst with i_Ready=1 -> all outputs 0 asynchronously; after release, o_Valid stays 0 until i_Start.
- Seed 4'hF: with LFSR_LOCKUP_GUARD_EN, o_Seed_Err pulses and the sequence starts from 0; without it, o_Data stays 1 forever and o_Wrap pulses every word.
